// File: rtl/sda_kernel_irq_pkg.sv
// Shared constants for the SDAccel kernel interrupt controller:
// register word addresses, interrupt source bit positions and bus FSM encoding.
package sda_kernel_irq_pkg;

  localparam int ADDR_GIE        = 0;
  localparam int ADDR_IER        = 1;
  localparam int ADDR_ISR        = 2;
  localparam int ADDR_DONE_COUNT = 3;

  localparam int IRQ_DONE  = 0;
  localparam int IRQ_READY = 1;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_ACK  = 1'b1;

endpackage

// File: rtl/sda_kernel_irq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module sda_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sda_kernel_irq_ctrl.sv
// SDAccel kernel interrupt controller: GIE/IER/ISR registers, done-run counter
// and a registered level interrupt, accessed over the reg_req/reg_ack bus.
//
// state | meaning
// IDLE  | waiting for reg_req; the access is performed in the cycle it is seen
// ACK   | reg_ack high for one cycle, reg_req ignored, always back to IDLE
module sda_kernel_irq_ctrl
  import sda_kernel_irq_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 2,
  parameter int COUNT_WIDTH    = 32,
  parameter int IRQ_SOURCES    = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      reg_req,
  output logic                      reg_ack,
  input  logic                      reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  input  logic                      done_event,
  input  logic                      ready_event,
  output logic                      ap_interrupt
);

  logic                   state_q, state_d;
  logic                   gie_q, gie_d;
  logic [IRQ_SOURCES-1:0] ier_q, ier_d;
  logic [IRQ_SOURCES-1:0] isr_q, isr_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   irq_q, irq_d;

  logic                   req_take, wr, rd;
  logic                   wr_gie, wr_ier, wr_isr, wr_cnt;
  logic [IRQ_SOURCES-1:0] ev, tow;
  logic [COUNT_WIDTH-1:0] done_count;
  logic [31:0]            rd_mux;
  logic                   unused_wdata;

  assign unused_wdata = ^reg_wdata[31:IRQ_SOURCES];

  always_comb begin
    req_take = (state_q == STATE_IDLE) && reg_req;
    wr       = req_take && reg_write_en;
    rd       = req_take && !reg_write_en;
    wr_gie   = wr && (reg_addr == REG_ADDR_WIDTH'(ADDR_GIE));
    wr_ier   = wr && (reg_addr == REG_ADDR_WIDTH'(ADDR_IER));
    wr_isr   = wr && (reg_addr == REG_ADDR_WIDTH'(ADDR_ISR));
    wr_cnt   = wr && (reg_addr == REG_ADDR_WIDTH'(ADDR_DONE_COUNT));

    state_d = req_take ? STATE_ACK : STATE_IDLE;

    ev            = '0;
    ev[IRQ_DONE]  = done_event;
    ev[IRQ_READY] = ready_event;
    tow           = wr_isr ? reg_wdata[IRQ_SOURCES-1:0] : '0;
    // Event is OR-ed after the toggle so a coincident event always wins.
    isr_d = (isr_q ^ tow) | ev;
    gie_d = wr_gie ? reg_wdata[0] : gie_q;
    ier_d = wr_ier ? reg_wdata[IRQ_SOURCES-1:0] : ier_q;

    // Reads see pre-update register state.
    if (reg_addr == REG_ADDR_WIDTH'(ADDR_GIE)) begin
      rd_mux = {31'd0, gie_q};
    end else if (reg_addr == REG_ADDR_WIDTH'(ADDR_IER)) begin
      rd_mux = 32'(ier_q);
    end else if (reg_addr == REG_ADDR_WIDTH'(ADDR_ISR)) begin
      rd_mux = 32'(isr_q);
    end else if (reg_addr == REG_ADDR_WIDTH'(ADDR_DONE_COUNT)) begin
      rd_mux = 32'(done_count);
    end else begin
      rd_mux = 32'd0;
    end
    rdata_d = rd ? rd_mux : rdata_q;

    irq_d = gie_q & (|(isr_q & ier_q));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= STATE_IDLE;
      gie_q   <= 1'b0;
      ier_q   <= '0;
      isr_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gie_q   <= gie_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  sda_sat_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_done_count (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (wr_cnt),
    .inc      (done_event),
    .count    (done_count)
  );

  assign reg_ack      = (state_q == STATE_ACK);
  assign reg_rdata    = rdata_q;
  assign ap_interrupt = irq_q;

endmodule

// File: tb/tb_sda_kernel_irq_ctrl.sv
// Directed bench for sda_kernel_irq_ctrl with a 4-bit done counter; bus
// responses are checked by a scoreboard monitor decoupled from the stimulus.
module tb_sda_kernel_irq_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        reg_req = 1'b0;
  logic        reg_ack;
  logic        reg_write_en = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        done_event = 1'b0;
  logic        ready_event = 1'b0;
  logic        ap_interrupt;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] last_rd = 32'd0;
  int          total = 0;
  int          bad = 0;

  always #5 ap_clk = ~ap_clk;

  sda_kernel_irq_ctrl #(
    .REG_ADDR_WIDTH(2),
    .COUNT_WIDTH   (4),
    .IRQ_SOURCES   (2)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .reg_req      (reg_req),
    .reg_ack      (reg_ack),
    .reg_write_en (reg_write_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .done_event   (done_event),
    .ready_event  (ready_event),
    .ap_interrupt (ap_interrupt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; reads check data, writes check rdata held.
  always @(negedge ap_clk) begin
    if (ap_rst_n && reg_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.is_rd ? "read_data" : "write_rdata_hold", reg_rdata, e.exp);
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic ev_done, input logic ev_ready);
    sb_t e;
    @(posedge ap_clk); #1;
    reg_req      = 1'b1;
    reg_write_en = we;
    reg_addr     = addr;
    reg_wdata    = wd;
    done_event   = ev_done;
    ready_event  = ev_ready;
    if (we) begin
      e.is_rd = 1'b0;
      e.exp   = last_rd;
    end else begin
      e.is_rd = 1'b1;
      e.exp   = exp_rd;
      last_rd = exp_rd;
    end
    sb_q.push_back(e);
    @(posedge ap_clk); #1;
    chk("ack_latency", {31'd0, reg_ack}, 32'd1);
    reg_req     = 1'b0;
    done_event  = 1'b0;
    ready_event = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    access(1'b1, addr, wd, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp);
    access(1'b0, addr, 32'd0, exp, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic d, input logic r);
    @(posedge ap_clk); #1;
    done_event  = d;
    ready_event = r;
    @(posedge ap_clk); #1;
    done_event  = 1'b0;
    ready_event = 1'b0;
  endtask

  task automatic irq_next(input string name, input logic now_v, input logic next_v);
    chk({name, "_now"}, {31'd0, ap_interrupt}, {31'd0, now_v});
    @(posedge ap_clk); #1;
    chk({name, "_next"}, {31'd0, ap_interrupt}, {31'd0, next_v});
  endtask

  initial begin
    #12;
    chk("rst_ack", {31'd0, reg_ack}, 32'd0);
    chk("rst_irq", {31'd0, ap_interrupt}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0);
    chk("irq_idle", {31'd0, ap_interrupt}, 32'd0);

    // Done event with GIE and IER[0] enabled
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    pulse(1'b1, 1'b0);
    irq_next("irq_done_set", 1'b0, 1'b1);
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h1);

    // Toggle-on-write clear, then event-wins collisions
    wr(2'd2, 32'h1);
    irq_next("irq_isr_clr", 1'b1, 1'b0);
    rd(2'd2, 32'h0);
    access(1'b1, 2'd2, 32'h1, 32'd0, 1'b1, 1'b0);
    access(1'b1, 2'd2, 32'h1, 32'd0, 1'b1, 1'b0);
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h3);

    // Ready event masked by IER, then unmasked
    wr(2'd2, 32'h1);
    pulse(1'b0, 1'b1);
    irq_next("irq_ready_masked", 1'b0, 1'b0);
    rd(2'd2, 32'h2);
    wr(2'd1, 32'h3);
    irq_next("irq_ier_on", 1'b0, 1'b1);
    rd(2'd1, 32'h3);

    // Simultaneous sources, then GIE drop
    wr(2'd2, 32'h2);
    pulse(1'b1, 1'b1);
    rd(2'd2, 32'h3);
    rd(2'd3, 32'h4);
    wr(2'd0, 32'h0);
    irq_next("irq_gie_off", 1'b1, 1'b0);
    rd(2'd0, 32'h0);

    // Unused write bits ignored
    wr(2'd0, 32'hFFFF_FFFE);
    rd(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFD);
    rd(2'd1, 32'h1);
    wr(2'd2, 32'hFFFF_FFFC);
    rd(2'd2, 32'h3);

    // Counter saturation and clear-with-increment
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h0);
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
    rd(2'd3, 32'hF);
    access(1'b1, 2'd3, 32'h0, 32'd0, 1'b1, 1'b0);
    rd(2'd3, 32'h1);

    // Reset during the ACK cycle of an IER write
    wr(2'd0, 32'h1);
    @(posedge ap_clk); #1;
    reg_req      = 1'b1;
    reg_write_en = 1'b1;
    reg_addr     = 2'd1;
    reg_wdata    = 32'h3;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, reg_ack}, 32'd0);
    chk("rst_mid_irq", {31'd0, ap_interrupt}, 32'd0);
    chk("rst_mid_rdata", reg_rdata, 32'd0);
    reg_req = 1'b0;
    last_rd = 32'd0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0);

    repeat (3) @(posedge ap_clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
